// File: rtl/paam_pkg.sv
// Shared helpers for the pipelined truncated approximate multiplier (PAAM).
// Optional exact-product mode is enabled with the PAAM_EXACT_MODE_EN macro.
package paam_pkg;

   // Partial product a[i]&b[j] survives truncation only above column k.
   function automatic logic keep_pp(int unsigned i, int unsigned j, int unsigned k);
      return (i + j) > k;
   endfunction

   // Bits [k:0] set, limited to w bits.
   function automatic logic [63:0] ones_mask(int unsigned k, int unsigned w);
      logic [63:0] m;
      m = '0;
      for (int unsigned b = 0; b < w && b < 64; b++) begin
         if (b <= k) m = m | (64'(1) << b);
      end
      return m;
   endfunction

   // Bit i set when a[i]&b[j] survives truncation.
   function automatic logic [63:0] keep_row_mask(int unsigned j, int unsigned k, int unsigned wa);
      logic [63:0] m;
      m = '0;
      for (int unsigned i = 0; i < wa && i < 64; i++) begin
         if (keep_pp(i, j, k)) m = m | (64'(1) << i);
      end
      return m;
   endfunction

   // First row reduced by stage s; leftover rows land in the last stage.
   function automatic int unsigned row_lo(int unsigned s, int unsigned wb, int unsigned lat);
      return s * (wb / lat);
   endfunction

   function automatic int unsigned row_hi(int unsigned s, int unsigned wb, int unsigned lat);
      return (s + 1 == lat) ? wb : (s + 1) * (wb / lat);
   endfunction

endpackage

// File: rtl/paam_pp_row.sv
// One masked partial-product row a & {WA{b[J]}} added into a WA+WB accumulator.
// With PAAM_EXACT_MODE_EN, an exact input re-enables the truncated terms.
module paam_pp_row
   import paam_pkg::*;
#(
   parameter int unsigned WA = 8,
   parameter int unsigned WB = 6,
   parameter int unsigned K  = 5,
   parameter int unsigned J  = 0
) (
   input  logic [WA-1:0]    a,
   input  logic             b_bit,
`ifdef PAAM_EXACT_MODE_EN
   input  logic             exact,
`endif
   input  logic [WA+WB-1:0] acc_in,
   output logic [WA+WB-1:0] acc_out
);

   localparam int unsigned PW = WA + WB;
   localparam logic [63:0] KeepFull = keep_row_mask(J, K, WA);
   localparam logic [WA-1:0] Keep = KeepFull[WA-1:0];

   logic [WA-1:0] row;

   // Constant mask lets synthesis drop the truncated AND gates entirely.
`ifdef PAAM_EXACT_MODE_EN
   assign row = a & {WA{b_bit}} & (Keep | {WA{exact}});
`else
   assign row = a & {WA{b_bit}} & Keep;
`endif

   assign acc_out = acc_in + (PW'(row) << J);

endmodule

// File: rtl/paam_pipe_mult.sv
// Pipelined PAAM multiplier with valid/ready flow control and a user tag.
// Define PAAM_EXACT_MODE_EN to add the in_exact port (per-op exact product).
module paam_pipe_mult
   import paam_pkg::*;
#(
   parameter int unsigned WA   = 8,
   parameter int unsigned WB   = 6,
   parameter int unsigned K    = 5,
   parameter int unsigned LAT  = 3,
   parameter int unsigned TAGW = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WA-1:0]      in_a,
   input  logic [WB-1:0]      in_b,
   input  logic [TAGW-1:0]    in_tag,
`ifdef PAAM_EXACT_MODE_EN
   input  logic               in_exact,
`endif
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WA+WB-1:0]   out_p,
   output logic [TAGW-1:0]    out_tag
);

   localparam int unsigned PW = WA + WB;
   localparam logic [63:0] MaskFull = ones_mask(K, PW);
   localparam logic [PW-1:0] Mask = MaskFull[PW-1:0];

   logic [LAT-1:0]  valid_q;
   logic [LAT-1:0]  v_src;
   logic [LAT-1:0]  ld;
   logic            tail_full;
   logic [PW-1:0]   acc_q   [LAT];
   logic [PW-1:0]   acc_d   [LAT];
   logic [PW-1:0]   acc_src [LAT];
   logic [WA-1:0]   a_q     [LAT];
   logic [WA-1:0]   a_src   [LAT];
   logic [WB-1:0]   b_q     [LAT];
   logic [WB-1:0]   b_src   [LAT];
   logic [TAGW-1:0] tag_q   [LAT];
   logic [TAGW-1:0] tag_src [LAT];
`ifdef PAAM_EXACT_MODE_EN
   logic [LAT-1:0]  ex_q;
   logic [LAT-1:0]  ex_src;
`endif

   // Stage s loads when any stage from s to the output is empty or the consumer takes a result.
   always_comb begin
      ld        = '0;
      tail_full = 1'b1;
      for (int s = LAT - 1; s >= 0; s--) begin
         tail_full = tail_full & valid_q[s];
         ld[s]     = out_ready | ~tail_full;
      end
   end

   assign in_ready = ld[0];

   always_comb begin
      v_src[0]   = in_valid;
      acc_src[0] = '0;
      a_src[0]   = in_a;
      b_src[0]   = in_b;
      tag_src[0] = in_tag;
`ifdef PAAM_EXACT_MODE_EN
      ex_src[0]  = in_exact;
`endif
      for (int s = 1; s < LAT; s++) begin
         v_src[s]   = valid_q[s-1];
         acc_src[s] = acc_q[s-1];
         a_src[s]   = a_q[s-1];
         b_src[s]   = b_q[s-1];
         tag_src[s] = tag_q[s-1];
`ifdef PAAM_EXACT_MODE_EN
         ex_src[s]  = ex_q[s-1];
`endif
      end
   end

   for (genvar s = 0; s < LAT; s++) begin : g_stage
      localparam int unsigned Lo   = row_lo(s, WB, LAT);
      localparam int unsigned Hi   = row_hi(s, WB, LAT);
      localparam int unsigned Rows = Hi - Lo;

      logic [PW-1:0] part [Rows+1];

      assign part[0] = acc_src[s];

      for (genvar r = 0; r < Rows; r++) begin : g_row
         paam_pp_row #(
            .WA (WA),
            .WB (WB),
            .K  (K),
            .J  (Lo + r)
         ) u_row (
            .a       (a_src[s]),
            .b_bit   (b_src[s][Lo+r]),
`ifdef PAAM_EXACT_MODE_EN
            .exact   (ex_src[s]),
`endif
            .acc_in  (part[r]),
            .acc_out (part[r+1])
         );
      end

      if (s == LAT - 1) begin : g_last
`ifdef PAAM_EXACT_MODE_EN
         assign acc_d[s] = ex_src[s] ? part[Rows] : (part[Rows] | Mask);
`else
         assign acc_d[s] = part[Rows] | Mask;
`endif
      end else begin : g_mid
         assign acc_d[s] = part[Rows];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
`ifdef PAAM_EXACT_MODE_EN
         ex_q    <= '0;
`endif
         for (int s = 0; s < LAT; s++) begin
            acc_q[s] <= '0;
            a_q[s]   <= '0;
            b_q[s]   <= '0;
            tag_q[s] <= '0;
         end
      end else begin
         for (int s = 0; s < LAT; s++) begin
            if (ld[s]) begin
               valid_q[s] <= v_src[s];
               // Bubbles leave the data registers untouched.
               if (v_src[s]) begin
                  acc_q[s] <= acc_d[s];
                  a_q[s]   <= a_src[s];
                  b_q[s]   <= b_src[s];
                  tag_q[s] <= tag_src[s];
`ifdef PAAM_EXACT_MODE_EN
                  ex_q[s]  <= ex_src[s];
`endif
               end
            end
         end
      end
   end

   assign out_valid = valid_q[LAT-1];
   assign out_p     = acc_q[LAT-1];
   assign out_tag   = tag_q[LAT-1];

endmodule
